// File: rtl/vga_timing_pkg.sv
// Shared raster constants and helpers for the VGA path (640x480@60 defaults).
// Renderers reuse h_total()/v_total() for address scaling.
package vga_timing_pkg;

    typedef logic [9:0] coord_t;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    function automatic int h_total(input int vis, input int front, input int sync, input int back);
        return vis + front + sync + back;
    endfunction

    function automatic int v_total(input int vis, input int front, input int sync, input int back);
        return vis + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay.sv
// Delays the {hs,vs} pair by DEPTH registered stages (0 = combinational bypass).
// Free-running, no backpressure; stages reset to the inactive sync level.
module sync_delay #(
    parameter int         DEPTH    = 1,
    parameter logic [1:0] INACTIVE = 2'b11
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] sync_i,
    output logic [1:0] sync_o
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ rst_ni;
        assign sync_o         = sync_i;
    end else begin : g_pipe
        logic [1:0] stage_q [DEPTH];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < DEPTH; i++) stage_q[i] <= INACTIVE;
            end else begin
                stage_q[0] <= sync_i;
                for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
            end
        end

        assign sync_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: DrawX/DrawY/blank same-cycle from counters, hs/vs delayed PIPE_DELAY cycles.
// Free-running on vga_clk, no backpressure; one start-up cycle after reset release.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE  = H_VISIBLE_DEF,
    parameter int H_FRONT    = H_FRONT_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BACK     = H_BACK_DEF,
    parameter int V_VISIBLE  = V_VISIBLE_DEF,
    parameter int V_FRONT    = V_FRONT_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BACK     = V_BACK_DEF,
    parameter bit SYNC_POL   = 1'b0,
    parameter int PIPE_DELAY = 1
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output coord_t     DrawX,
    output coord_t     DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > 4) begin : g_bad_delay
        $error("vga_timing_gen: PIPE_DELAY must be within 0..4");
    end

    localparam coord_t      H_LAST = coord_t'(H_TOTAL - 1);
    localparam coord_t      V_LAST = coord_t'(V_TOTAL - 1);
    // 11-bit bounds so a window ending exactly at 1024 still compares correctly
    localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
    localparam logic [10:0] HS_BEG = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_BEG = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic       run_q;
    coord_t     x_q, x_d, y_q, y_d;
    logic [7:0] fc_q, fc_d;
    logic       hs_win, vs_win, hs_raw, vs_raw;
    logic [1:0] sync_dly;

    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        fc_d = fc_q;
        if (run_q) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                if (y_q == V_LAST) begin
                    y_d  = '0;
                    fc_d = fc_q + 8'd1;
                end else begin
                    y_d = y_q + 10'd1;
                end
            end else begin
                x_d = x_q + 10'd1;
            end
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q <= 1'b0;
            x_q   <= '0;
            y_q   <= '0;
            fc_q  <= '0;
        end else begin
            run_q <= 1'b1;
            x_q   <= x_d;
            y_q   <= y_d;
            fc_q  <= fc_d;
        end
    end

    assign hs_win = ({1'b0, x_q} >= HS_BEG) && ({1'b0, x_q} < HS_END);
    assign vs_win = ({1'b0, y_q} >= VS_BEG) && ({1'b0, y_q} < VS_END);
    assign hs_raw = hs_win ? SYNC_POL : ~SYNC_POL;
    assign vs_raw = vs_win ? SYNC_POL : ~SYNC_POL;

    sync_delay #(
        .DEPTH    (PIPE_DELAY),
        .INACTIVE ({~SYNC_POL, ~SYNC_POL})
    ) u_sync_delay (
        .clk_i  (vga_clk),
        .rst_ni (reset_n),
        .sync_i ({hs_raw, vs_raw}),
        .sync_o (sync_dly)
    );

    assign hs          = sync_dly[1];
    assign vs          = sync_dly[0];
    assign DrawX       = x_q;
    assign DrawY       = y_q;
    assign blank       = run_q && ({1'b0, x_q} < H_VIS) && ({1'b0, y_q} < V_VIS);
    assign line_start  = run_q && (x_q == '0);
    assign frame_start = line_start && (y_q == '0);
    assign frame_count = fc_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing source for the VGA path: generates the pixel coordinates DrawX/DrawY, the visible-area flag blank, and the hs/vs sync pulses for 640x480@60.
- Sits directly upstream of the sprite/round renderers, which consume DrawX, DrawY and blank on vga_clk and register RGB one cycle later.
- hs/vs are delayed by a programmable pipeline depth so sync stays aligned with the renderers' registered colour output.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (cycles)
- H_SYNC, 96, horizontal sync width (cycles)
- H_BACK, 48, horizontal back porch (cycles)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low)
- PIPE_DELAY, 1, hs/vs delay in cycles to match downstream RGB latency (0..4)

Ports:
- vga_clk  input  1  pixel clock; all state on posedge
- reset_n  input  1  asynchronous, active-low reset
- DrawX  output  10  current horizontal count, 0..H_TOTAL-1
- DrawY  output  10  current vertical count, 0..V_TOTAL-1
- blank  output  1  1 = visible pixel (downstream drives colour only when 1)
- hs  output  1  horizontal sync, delayed PIPE_DELAY cycles
- vs  output  1  vertical sync, delayed PIPE_DELAY cycles
- line_start  output  1  one-cycle pulse when DrawX==0
- frame_start  output  1  one-cycle pulse when DrawX==0 and DrawY==0
- frame_count  output  8  frames completed since reset, wraps modulo 256

Behaviour:
- Interface: one clock (vga_clk); reset is asynchronous and active-low (reset_n).
- Derived totals: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525).
  - Elaboration error if H_TOTAL>1024 or V_TOTAL>1024.
  - Elaboration error if PIPE_DELAY is outside 0..4.
- Reset values (asserted asynchronously):
  - DrawX=0, DrawY=0, blank=0, line_start=0, frame_start=0, frame_count=0.
  - hs=vs=~SYNC_POL (inactive); all delay stages also hold the inactive level.
- Start-up:
  - A registered run flag clears on reset and sets on the first posedge after release.
  - While run=0, counters hold 0 and blank, line_start and frame_start are 0.
- Counting (run=1):
  - DrawX increments every cycle; at H_TOTAL-1 it wraps to 0 and DrawY increments.
  - DrawY wraps from V_TOTAL-1 to 0 on the same edge that DrawX wraps.
- blank = run & (DrawX<H_VISIBLE) & (DrawY<V_VISIBLE). It is aligned with DrawX/DrawY (same cycle, no delay).
- Raw sync, before delay:
  - hs_raw is active when H_VISIBLE+H_FRONT <= DrawX < H_VISIBLE+H_FRONT+H_SYNC (656..751).
  - vs_raw is active when V_VISIBLE+V_FRONT <= DrawY < V_VISIBLE+V_FRONT+V_SYNC (490..491), for whole lines.
- Sync delay: hs/vs equal hs_raw/vs_raw delayed by PIPE_DELAY registered stages. PIPE_DELAY=0 means combinational pass-through.
- Pulses:
  - line_start = run & (DrawX==0).
  - frame_start = line_start & (DrawY==0).
  - The first frame_start after reset occurs in the first cycle with run=1.
- frame_count increments on the edge where (DrawX,DrawY) wraps from (H_TOTAL-1, V_TOTAL-1) to (0,0). It wraps 255->0 and is not saturating.
- Reset mid-frame: all outputs return to reset values immediately. Counting restarts from (0,0) with the start-up cycle; no partial-frame state is retained.
- Counter width: counters are 10-bit unsigned. The compare logic never depends on overflow.

Decomposition:
- Shared package vga_timing_pkg:
  - typedef coord_t (logic [9:0]).
  - 640x480@60 default constants.
  - Functions h_total()/v_total() for derived totals, reused by renderers for address scaling.
- One sub-module, sync_delay: a 2-bit wide shift register of depth PIPE_DELAY, reset to the inactive level, with a depth-0 bypass.

Test Plan:
- Hold reset_n=0 for 10 cycles, then release:
  - During reset: DrawX=0, DrawY=0, blank=0, hs=vs=1, frame_count=0.
  - First cycle after release: still (0,0) with blank=0.
  - Next cycle: blank=1, frame_start=1.
- Default params, PIPE_DELAY=1, one line:
  - blank=1 for exactly 640 consecutive cycles per line.
  - hs is low for 96 cycles, first low in the cycle where DrawX=657.
  - Line period is 800 cycles; line_start pulses once per line.
- Full frame:
  - vs is low for 1600 cycles, from DrawY=490,DrawX=1 through DrawY=492,DrawX=0.
  - frame_start period is 420000 cycles; frame_count goes 0->1 at the first wrap.
- Wrap, small params (H 8/2/2/2, V 4/1/1/1): run 256 frames -> frame_count returns 255->0 on the wrap from (13,6) to (0,0), with frame_start=1 that cycle.
- Reset mid-frame: assert reset_n=0 asynchronously at DrawX=300, DrawY=200 -> all outputs reach reset values before the next posedge; after release, counting resumes from (0,0).
- PIPE_DELAY=0 -> hs low in the exact cycle DrawX=656; PIPE_DELAY=3 -> hs low first at DrawX=659.
